// File: rtl/mips_main_control_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_main_control_if
// Description : Bundle between the multicycle main-control FSM and the MIPS
//               datapath / memory. The controller (master) receives the opcode
//               and the memory-ready handshake and drives every datapath
//               strobe plus the debug/status outputs.
//   Ports (master view):
//     op[5:0]        in   opcode from the instruction register
//     mem_ready      in   memory completes current MemRead/MemWrite
//     PCWriteCond    out  PC write qualified by ALU zero
//     PCWrite        out  unconditional PC write
//     PCSource[1:0]  out  00 ALU result, 01 ALU register, 10 jump target
//     IorD           out  memory address select: 0 PC, 1 ALU register
//     MemRead        out  memory read strobe
//     MemWrite       out  memory write strobe
//     MemToReg       out  write-back select: 0 ALU register, 1 memory data
//     IRWrite        out  instruction register load
//     RegWrite       out  register file write
//     RegDst         out  write address select: 0 rt, 1 rd
//     ALUSrcA        out  ALU A select: 0 PC, 1 A register
//     ALUSrcB[1:0]   out  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//     ALUOp[1:0]     out  00 add, 01 sub, 10 decode by funct
//     illegal        out  sticky unsupported-opcode flag
//     state[3:0]     out  current FSM state (debug)
//     instret        out  retired-instruction count, CNT_W bits
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_main_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       op;
  logic             mem_ready;
  logic             PCWriteCond;
  logic             PCWrite;
  logic [1:0]       PCSource;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             MemToReg;
  logic             IRWrite;
  logic             RegWrite;
  logic             RegDst;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic             illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] instret;

  modport master (
    input  op, mem_ready,
    output PCWriteCond, PCWrite, PCSource, IorD, MemRead, MemWrite,
           MemToReg, IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp,
           illegal, state, instret
  );

  modport slave (
    output op, mem_ready,
    input  PCWriteCond, PCWrite, PCSource, IorD, MemRead, MemWrite,
           MemToReg, IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp,
           illegal, state, instret
  );
endinterface
`default_nettype wire

// File: rtl/mips_main_control.sv
`default_nettype none
// ============================================================================
// Module      : mips_main_control
// Description : Multicycle MIPS main-control FSM (R-type, lw, sw, beq, j,
//               addi). Moore control strobes, except that IRWrite/PCWrite in
//               FETCH are qualified by mem_ready. Memory states hold until
//               mem_ready. Counts retired instructions in instret.
//   Ports:
//     clk    in   rising-edge clock
//     reset  in   asynchronous active-low reset
//     bus    master modport of mips_main_control_if (opcode, handshake,
//            all control strobes, illegal, state, instret)
// Revision    : 1.0 - initial release
// ============================================================================
module mips_main_control #(
  parameter int CNT_W = 32
) (
  input  wire logic             clk,
  input  wire logic             reset,
  mips_main_control_if.master   bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11,
    ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_instret;
  logic             r_illegal;
  logic             w_retire;

  logic       w_pcWriteCond, w_pcWrite, w_iorD, w_memRead, w_memWrite;
  logic       w_memToReg, w_irWrite, w_regWrite, w_regDst, w_aluSrcA;
  logic [1:0] w_pcSource, w_aluSrcB, w_aluOp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= FETCH;
      r_instret <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_retire) begin
        r_instret <= r_instret + CNT_W'(1);
      end
      if (w_nextState == ILLEGAL) begin
        r_illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_retire      = 1'b0;
    w_pcWriteCond = 1'b0;
    w_pcWrite     = 1'b0;
    w_pcSource    = 2'b00;
    w_iorD        = 1'b0;
    w_memRead     = 1'b0;
    w_memWrite    = 1'b0;
    w_memToReg    = 1'b0;
    w_irWrite     = 1'b0;
    w_regWrite    = 1'b0;
    w_regDst      = 1'b0;
    w_aluSrcA     = 1'b0;
    w_aluSrcB     = 2'b00;
    w_aluOp       = 2'b00;
    case (r_state)
      FETCH: begin
        w_memRead = 1'b1;
        w_aluSrcB = 2'b01;
        // The IR load and PC+4 update only happen in the cycle the memory
        // actually returns the instruction.
        if (bus.mem_ready) begin
          w_irWrite   = 1'b1;
          w_pcWrite   = 1'b1;
          w_nextState = DECODE;
        end
      end
      DECODE: begin
        w_aluSrcB = 2'b11;
        case (bus.op)
          c_OP_LW, c_OP_SW: w_nextState = MEMADR;
          c_OP_RTYPE:       w_nextState = EXEC;
          c_OP_BEQ:         w_nextState = BRANCH;
          c_OP_J:           w_nextState = JUMP;
          c_OP_ADDI:        w_nextState = ADDIEX;
          default:          w_nextState = ILLEGAL;
        endcase
      end
      MEMADR: begin
        w_aluSrcA   = 1'b1;
        w_aluSrcB   = 2'b10;
        w_nextState = (bus.op == c_OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        w_memRead = 1'b1;
        w_iorD    = 1'b1;
        if (bus.mem_ready) w_nextState = MEMWB;
      end
      MEMWB: begin
        w_regWrite  = 1'b1;
        w_memToReg  = 1'b1;
        w_retire    = 1'b1;
        w_nextState = FETCH;
      end
      MEMWR: begin
        w_memWrite = 1'b1;
        w_iorD     = 1'b1;
        if (bus.mem_ready) begin
          w_retire    = 1'b1;
          w_nextState = FETCH;
        end
      end
      EXEC: begin
        w_aluSrcA   = 1'b1;
        w_aluOp     = 2'b10;
        w_nextState = ALUWB;
      end
      ALUWB: begin
        w_regWrite  = 1'b1;
        w_regDst    = 1'b1;
        w_retire    = 1'b1;
        w_nextState = FETCH;
      end
      BRANCH: begin
        w_aluSrcA     = 1'b1;
        w_aluOp       = 2'b01;
        w_pcWriteCond = 1'b1;
        w_pcSource    = 2'b01;
        w_retire      = 1'b1;
        w_nextState   = FETCH;
      end
      JUMP: begin
        w_pcWrite   = 1'b1;
        w_pcSource  = 2'b10;
        w_retire    = 1'b1;
        w_nextState = FETCH;
      end
      ADDIEX: begin
        w_aluSrcA   = 1'b1;
        w_aluSrcB   = 2'b10;
        w_nextState = ADDIWB;
      end
      ADDIWB: begin
        w_regWrite  = 1'b1;
        w_retire    = 1'b1;
        w_nextState = FETCH;
      end
      ILLEGAL: w_nextState = ILLEGAL;
      // Encodings 13-15 recover to FETCH without retiring anything.
      default: w_nextState = FETCH;
    endcase
  end

  // Strobes are gated by reset so FETCH's MemRead etc. never leak out while
  // reset is held low.
  assign bus.PCWriteCond = reset & w_pcWriteCond;
  assign bus.PCWrite     = reset & w_pcWrite;
  assign bus.PCSource    = reset ? w_pcSource : 2'b00;
  assign bus.IorD        = reset & w_iorD;
  assign bus.MemRead     = reset & w_memRead;
  assign bus.MemWrite    = reset & w_memWrite;
  assign bus.MemToReg    = reset & w_memToReg;
  assign bus.IRWrite     = reset & w_irWrite;
  assign bus.RegWrite    = reset & w_regWrite;
  assign bus.RegDst      = reset & w_regDst;
  assign bus.ALUSrcA     = reset & w_aluSrcA;
  assign bus.ALUSrcB     = reset ? w_aluSrcB : 2'b00;
  assign bus.ALUOp       = reset ? w_aluOp : 2'b00;
  assign bus.illegal     = r_illegal;
  assign bus.state       = r_state;
  assign bus.instret     = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_mips_main_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_main_control
// Description : Scoreboard bench for mips_main_control. Stimulus pushes the
//               hand-derived expected outputs for each cycle; a monitor pops
//               and compares them on the falling clock edge (or on demand for
//               the asynchronous-reset check).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_main_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct packed {
    logic [3:0] st;
    logic       pcwc;
    logic       pcw;
    logic [1:0] pcs;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       m2r;
    logic       irw;
    logic       rw;
    logic       rd;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] aop;
    logic       ill;
    logic [3:0] cnt;
  } exp_t;

  logic clk;
  logic reset;
  event sampleEv;

  exp_t  expQ[$];
  string nameQ[$];
  int    nCompared;
  int    nMismatched;

  mips_main_control_if #(.CNT_W(4)) bus ();

  mips_main_control #(.CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected Moore controls per state, written from the state table.
  function automatic exp_t ctl(input int s, input logic mr);
    exp_t e;
    e = '0;
    case (s)
      0:  begin e.mrd = 1; e.asb = 2'b01; e.irw = mr; e.pcw = mr; end
      1:  e.asb = 2'b11;
      2:  begin e.asa = 1; e.asb = 2'b10; end
      3:  begin e.mrd = 1; e.iord = 1; end
      4:  begin e.rw = 1; e.m2r = 1; end
      5:  begin e.mwr = 1; e.iord = 1; end
      6:  begin e.asa = 1; e.aop = 2'b10; end
      7:  begin e.rw = 1; e.rd = 1; end
      8:  begin e.asa = 1; e.aop = 2'b01; e.pcwc = 1; e.pcs = 2'b01; end
      9:  begin e.pcw = 1; e.pcs = 2'b10; end
      10: begin e.asa = 1; e.asb = 2'b10; end
      11: e.rw = 1;
      12: e.ill = 1;
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic exp_t mkExp(input logic inRst, input int s, input logic mr, input int n);
    exp_t e;
    if (inRst) begin
      e = '0;
    end else begin
      e     = ctl(s, mr);
      e.st  = 4'(s);
      e.cnt = 4'(n);
    end
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t a;
    a.st   = bus.state;
    a.pcwc = bus.PCWriteCond;
    a.pcw  = bus.PCWrite;
    a.pcs  = bus.PCSource;
    a.iord = bus.IorD;
    a.mrd  = bus.MemRead;
    a.mwr  = bus.MemWrite;
    a.m2r  = bus.MemToReg;
    a.irw  = bus.IRWrite;
    a.rw   = bus.RegWrite;
    a.rd   = bus.RegDst;
    a.asa  = bus.ALUSrcA;
    a.asb  = bus.ALUSrcB;
    a.aop  = bus.ALUOp;
    a.ill  = bus.illegal;
    a.cnt  = bus.instret;
    return a;
  endfunction

  // One clock cycle of stimulus; called at posedge+1.
  task automatic cyc(input string nm, input logic inRst, input logic [5:0] o,
                     input logic mr, input int s, input int n);
    reset         = inRst ? 1'b0 : 1'b1;
    bus.op        = o;
    bus.mem_ready = mr;
    expQ.push_back(mkExp(inRst, s, mr, n));
    nameQ.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Monitor
  initial begin
    exp_t  e;
    exp_t  a;
    string nm;
    nCompared   = 0;
    nMismatched = 0;
    forever begin
      @(negedge clk or sampleEv);
      if (expQ.size() > 0) begin
        e  = expQ.pop_front();
        nm = nameQ.pop_front();
        a  = sample();
        nCompared++;
        if (a !== e) begin
          nMismatched++;
          $display("FAIL %s: got %h (state %0d instret %0d) required %h (state %0d instret %0d)",
                   nm, a, a.st, a.cnt, e, e.st, e.cnt);
        end
      end
    end
  end

  // Stimulus
  initial begin
    reset         = 1'b0;
    bus.op        = OP_R;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;

    cyc("reset0", 1, OP_R, 1, 0, 0);
    cyc("reset1", 1, OP_R, 1, 0, 0);

    // R-type
    cyc("r_fetch",  0, OP_R, 1, 0, 0);
    cyc("r_decode", 0, OP_R, 1, 1, 0);
    cyc("r_exec",   0, OP_R, 1, 6, 0);
    cyc("r_aluwb",  0, OP_R, 1, 7, 0);

    // lw with two-cycle stall in MEMRD
    cyc("lw_fetch",  0, OP_LW, 1, 0, 1);
    cyc("lw_decode", 0, OP_LW, 1, 1, 1);
    cyc("lw_memadr", 0, OP_LW, 1, 2, 1);
    cyc("lw_memrd0", 0, OP_LW, 0, 3, 1);
    cyc("lw_memrd1", 0, OP_LW, 0, 3, 1);
    cyc("lw_memrd2", 0, OP_LW, 1, 3, 1);
    cyc("lw_memwb",  0, OP_LW, 1, 4, 1);

    // addi with three-cycle FETCH stall
    cyc("ad_fstall0", 0, OP_ADDI, 0, 0, 2);
    cyc("ad_fstall1", 0, OP_ADDI, 0, 0, 2);
    cyc("ad_fstall2", 0, OP_ADDI, 0, 0, 2);
    cyc("ad_fetch",   0, OP_ADDI, 1, 0, 2);
    cyc("ad_decode",  0, OP_ADDI, 1, 1, 2);
    cyc("ad_ex",      0, OP_ADDI, 1, 10, 2);
    cyc("ad_wb",      0, OP_ADDI, 1, 11, 2);

    // sw with one-cycle stall in MEMWR
    cyc("sw_fetch",  0, OP_SW, 1, 0, 3);
    cyc("sw_decode", 0, OP_SW, 1, 1, 3);
    cyc("sw_memadr", 0, OP_SW, 1, 2, 3);
    cyc("sw_memwr0", 0, OP_SW, 0, 5, 3);
    cyc("sw_memwr1", 0, OP_SW, 1, 5, 3);

    // beq then j
    cyc("beq_fetch",  0, OP_BEQ, 1, 0, 4);
    cyc("beq_decode", 0, OP_BEQ, 1, 1, 4);
    cyc("beq_branch", 0, OP_BEQ, 1, 8, 4);
    cyc("j_fetch",    0, OP_J,   1, 0, 5);
    cyc("j_decode",   0, OP_J,   1, 1, 5);
    cyc("j_jump",     0, OP_J,   1, 9, 5);

    // Ten more jumps take the 4-bit counter from 6 through 15 and wrap to 0
    for (int i = 0; i < 10; i++) begin
      cyc("jl_fetch",  0, OP_J, 1, 0, (6 + i) % 16);
      cyc("jl_decode", 0, OP_J, 1, 1, (6 + i) % 16);
      cyc("jl_jump",   0, OP_J, 1, 9, (6 + i) % 16);
    end

    // Illegal opcode: terminal, illegal=1, all controls 0
    cyc("il_fetch_wrap", 0, OP_BAD, 1, 0, 0);
    cyc("il_decode",     0, OP_BAD, 1, 1, 0);
    for (int i = 0; i < 10; i++) begin
      cyc("il_hold", 0, OP_BAD, logic'(i % 2), 12, 0);
    end
    cyc("il_reset",   1, OP_SW, 1, 0, 0);

    // sw interrupted by asynchronous reset in MEMWR
    cyc("sr_fetch",  0, OP_SW, 1, 0, 0);
    cyc("sr_decode", 0, OP_SW, 1, 1, 0);
    cyc("sr_memadr", 0, OP_SW, 1, 2, 0);
    reset         = 1'b1;
    bus.mem_ready = 1'b0;
    expQ.push_back(mkExp(0, 5, 0, 0));
    nameQ.push_back("sr_memwr");
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    expQ.push_back(mkExp(1, 0, 0, 0));
    nameQ.push_back("sr_async_reset");
    ->sampleEv;
    #1;
    @(posedge clk);
    #1;
    cyc("sr_reset_hold", 1, OP_SW, 1, 0, 0);
    cyc("sr_restart",    0, OP_SW, 1, 0, 0);
    cyc("sr_decode2",    0, OP_SW, 1, 1, 0);

    #2;
    nCompared++;
    if (expQ.size() != 0) begin
      nMismatched++;
      $display("FAIL drain: got %0d pending entries, required 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire
